// File: rtl/cadence_pkg.sv
// Shared constants and helpers for the multi-channel cadence debounce filter.
package cadence_pkg;

  localparam int STABLE_CYC_DEF = 50000;
  localparam int PER_W_DEF      = 24;

  // Increment that sticks at the all-ones value of a width-bit field instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/cadence_filt_mc_if.sv
// Sensor-side bundle: raw cadence pins in, debounced levels, edge pulses and periods out.
interface cadence_filt_mc_if
  import cadence_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int PER_W = PER_W_DEF
);

  logic [N_CH-1:0]       cadence;
  logic [N_CH-1:0]       cadence_filt;
  logic [N_CH-1:0]       rise;
  logic [N_CH-1:0]       fall;
  logic [N_CH*PER_W-1:0] period;
  logic [N_CH-1:0]       period_vld;

  modport master (
    output cadence,
    input  cadence_filt, rise, fall, period, period_vld
  );

  modport slave (
    input  cadence,
    output cadence_filt, rise, fall, period, period_vld
  );

endinterface

// File: rtl/cadence_filt_ch.sv
// One cadence channel: 2-flop synchroniser, stability-window debounce,
// registered edge pulses and saturating rise-to-rise period measurement.
module cadence_filt_ch
  import cadence_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int PER_W      = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cadence,
  output logic             cadence_filt,
  output logic             rise,
  output logic             fall,
  output logic [PER_W-1:0] period,
  output logic             period_vld
);

  localparam int            CW       = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

  logic             s1;
  logic             s2;
  logic [CW-1:0]    stab_cnt;
  logic [PER_W-1:0] per_cnt;
  logic             armed;
  logic             window_done;
  logic             rise_now;

  always_comb begin
    window_done = 1'b0;
    rise_now    = 1'b0;
    window_done = (s2 != cadence_filt) && (stab_cnt == CNT_LAST);
    rise_now    = window_done && !cadence_filt;
  end

  // The window restarts whenever the synchronised level agrees with the filtered one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      stab_cnt     <= '0;
      cadence_filt <= 1'b0;
      rise         <= 1'b0;
      fall         <= 1'b0;
    end else begin
      s1   <= cadence;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == cadence_filt) begin
        stab_cnt <= '0;
      end else if (window_done) begin
        stab_cnt     <= '0;
        cadence_filt <= ~cadence_filt;
        rise         <= ~cadence_filt;
        fall         <= cadence_filt;
      end else begin
        stab_cnt <= stab_cnt + CW'(1);
      end
    end
  end

  // The first rise after reset only arms the measurement; it has no previous rise to measure from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt    <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      armed      <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (rise_now) begin
        per_cnt <= '0;
        armed   <= 1'b1;
        if (armed) begin
          period     <= PER_W'(sat_inc(64'(per_cnt), PER_W));
          period_vld <= 1'b1;
        end
      end else begin
        per_cnt <= PER_W'(sat_inc(64'(per_cnt), PER_W));
      end
    end
  end

endmodule

// File: rtl/cadence_filt_mc.sv
// N independent cadence debounce channels packed onto one sensor-side interface.
module cadence_filt_mc
  import cadence_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int PER_W      = PER_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  cadence_filt_mc_if.slave bus
);

  logic [N_CH-1:0]       filt_w;
  logic [N_CH-1:0]       rise_w;
  logic [N_CH-1:0]       fall_w;
  logic [N_CH-1:0]       vld_w;
  logic [N_CH*PER_W-1:0] period_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cadence_filt_ch #(
      .STABLE_CYC (STABLE_CYC),
      .PER_W      (PER_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .cadence      (bus.cadence[i]),
      .cadence_filt (filt_w[i]),
      .rise         (rise_w[i]),
      .fall         (fall_w[i]),
      .period       (period_w[i*PER_W +: PER_W]),
      .period_vld   (vld_w[i])
    );
  end

  assign bus.cadence_filt = filt_w;
  assign bus.rise         = rise_w;
  assign bus.fall         = fall_w;
  assign bus.period       = period_w;
  assign bus.period_vld   = vld_w;

endmodule

// File: tb/tb_cadence_filt_mc.sv
// Directed bench for cadence_filt_mc: a 2-channel 24-bit instance and a
// 1-channel 8-bit instance, both with a 16-cycle stability window.
module tb_cadence_filt_mc;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  cadence_filt_mc_if #(.N_CH(2), .PER_W(24)) bus ();
  cadence_filt_mc_if #(.N_CH(1), .PER_W(8))  bus8 ();

  cadence_filt_mc #(.N_CH(2), .STABLE_CYC(16), .PER_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  cadence_filt_mc #(.N_CH(1), .STABLE_CYC(16), .PER_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every observed change of the filtered level on the 2-channel instance.
  logic [1:0] filt_prev = 2'b00;
  int         trans0    = 0;
  int         trans1    = 0;
  always @(negedge clk) begin
    if (bus.cadence_filt[0] != filt_prev[0]) trans0++;
    if (bus.cadence_filt[1] != filt_prev[1]) trans1++;
    filt_prev = bus.cadence_filt;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b1;
    bus.cadence  = 2'b11;
    bus8.cadence = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.cadence_filt !== 2'b00 || bus.rise !== 2'b00 || bus.fall !== 2'b00 || bus.period_vld !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got filt=%b rise=%b fall=%b vld=%b, expected all 0", bus.cadence_filt, bus.rise, bus.fall, bus.period_vld);
    end
    n_checks++;
    if (bus.period !== 48'h0 || bus8.period !== 8'h0 || bus8.cadence_filt !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_period: got %h / %h filt8=%b, expected 0", bus.period, bus8.period, bus8.cadence_filt);
    end
    tick(2);
    rst_n = 1'b1;
    tick(17);
    n_checks++;
    if (bus.cadence_filt !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_edge17_filt: got %b expected 00", bus.cadence_filt);
    end
    tick(1);
    n_checks++;
    if (bus.cadence_filt !== 2'b11 || bus.rise !== 2'b11 || bus.fall !== 2'b00 || bus.period_vld !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_edge18: got filt=%b rise=%b fall=%b vld=%b, expected 11/11/00/00", bus.cadence_filt, bus.rise, bus.fall, bus.period_vld);
    end
    tick(1);
    n_checks++;
    if (bus.cadence_filt !== 2'b11 || bus.rise !== 2'b00 || bus.period_vld !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_edge19: got filt=%b rise=%b vld=%b, expected 11/00/00", bus.cadence_filt, bus.rise, bus.period_vld);
    end
  endtask

  task automatic test_noise();
    int start0;
    int start1;
    start0 = trans0;
    start1 = trans1;
    fork
      begin
        for (int r = 0; r < 100; r++) begin
          bus.cadence[0] = 1'b0;
          tick(15);
          bus.cadence[0] = 1'b1;
          tick(2);
        end
      end
      begin
        logic target;
        target = 1'b0;
        for (int it = 0; it < 20; it++) begin
          int len;
          len = $urandom_range(1, 15);
          for (int b = 0; b < len; b++) begin
            bus.cadence[1] = 1'($urandom_range(0, 1));
            tick(1);
          end
          bus.cadence[1] = target;
          tick(80);
          n_checks++;
          if (bus.cadence_filt[1] !== target) begin
            n_fail++;
            $display("[TB] FAIL noise_ch1_level it=%0d: got %b expected %b", it, bus.cadence_filt[1], target);
          end
          target = ~target;
        end
      end
    join
    tick(1);
    n_checks++;
    if (trans0 - start0 !== 0 || bus.cadence_filt[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL noise_ch0_stable: got %0d transitions filt=%b, expected 0 transitions filt=1", trans0 - start0, bus.cadence_filt[0]);
    end
    n_checks++;
    if (trans1 - start1 !== 20) begin
      n_fail++;
      $display("[TB] FAIL noise_ch1_transitions: got %0d expected 20", trans1 - start1);
    end
  endtask

  task automatic test_period();
    bus.cadence = 2'b00;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.cadence[0] = 1'b1;
      tick(17);
      n_checks++;
      if (bus.cadence_filt[0] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL period_early_filt k=%0d: got %b expected 0", k, bus.cadence_filt[0]);
      end
      tick(1);
      n_checks++;
      if (bus.rise !== 2'b01 || bus.period_vld !== ((k > 0) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("[TB] FAIL period_rise k=%0d: got rise=%b vld=%b, expected 01/%b", k, bus.rise, bus.period_vld, (k > 0) ? 2'b01 : 2'b00);
      end
      if (k > 0) begin
        n_checks++;
        if (bus.period[23:0] !== 24'd200 || bus.period[47:24] !== 24'd0) begin
          n_fail++;
          $display("[TB] FAIL period_value k=%0d: got ch0=%0d ch1=%0d expected 200/0", k, bus.period[23:0], bus.period[47:24]);
        end
      end
      tick(1);
      n_checks++;
      if (bus.period_vld !== 2'b00 || bus.rise !== 2'b00 || bus.period[23:0] !== ((k > 0) ? 24'd200 : 24'd0)) begin
        n_fail++;
        $display("[TB] FAIL period_hold k=%0d: got vld=%b rise=%b period=%0d", k, bus.period_vld, bus.rise, bus.period[23:0]);
      end
      tick(81);
      bus.cadence[0] = 1'b0;
      tick(100);
    end
  endtask

  task automatic test_per_w8();
    for (int k = 0; k < 3; k++) begin
      bus8.cadence = 1'b1;
      tick(18);
      n_checks++;
      if (bus8.rise !== 1'b1 || bus8.period_vld !== ((k > 0) ? 1'b1 : 1'b0) || bus8.period !== ((k > 0) ? 8'hFF : 8'h00)) begin
        n_fail++;
        $display("[TB] FAIL per_w8_sat k=%0d: got rise=%b vld=%b period=%h, expected 1/%b/%h", k, bus8.rise, bus8.period_vld, bus8.period, (k > 0) ? 1'b1 : 1'b0, (k > 0) ? 8'hFF : 8'h00);
      end
      tick(132);
      bus8.cadence = 1'b0;
      tick(150);
    end
  endtask

  task automatic test_simultaneous();
    bus.cadence = 2'b00;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    bus.cadence = 2'b11;
    tick(17);
    n_checks++;
    if (bus.cadence_filt !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL simul_early: got %b expected 00", bus.cadence_filt);
    end
    tick(1);
    n_checks++;
    if (bus.cadence_filt !== 2'b11 || bus.rise !== 2'b11 || bus.period_vld !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL simul_first_rise: got filt=%b rise=%b vld=%b, expected 11/11/00", bus.cadence_filt, bus.rise, bus.period_vld);
    end
    tick(1);
    n_checks++;
    if (bus.rise !== 2'b00 || bus.fall !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL simul_pulse_width: got rise=%b fall=%b expected 00/00", bus.rise, bus.fall);
    end
    tick(41);
    bus.cadence = 2'b00;
    tick(18);
    n_checks++;
    if (bus.cadence_filt !== 2'b00 || bus.fall !== 2'b11 || bus.rise !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL simul_fall: got filt=%b fall=%b rise=%b, expected 00/11/00", bus.cadence_filt, bus.fall, bus.rise);
    end
    tick(42);
    bus.cadence = 2'b11;
    tick(18);
    n_checks++;
    if (bus.rise !== 2'b11 || bus.period_vld !== 2'b11 || bus.period !== {24'd120, 24'd120}) begin
      n_fail++;
      $display("[TB] FAIL simul_period: got rise=%b vld=%b ch0=%0d ch1=%0d, expected 11/11/120/120", bus.rise, bus.period_vld, bus.period[23:0], bus.period[47:24]);
    end
  endtask

  task automatic test_reset_midcount();
    tick(138);
    bus.cadence[0] = 1'b0;
    tick(12);
    n_checks++;
    if (bus.cadence_filt !== 2'b11 || bus.period !== {24'd120, 24'd120}) begin
      n_fail++;
      $display("[TB] FAIL midcount_pre: got filt=%b period=%h, expected 11 and 120/120", bus.cadence_filt, bus.period);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.cadence_filt !== 2'b00 || bus.rise !== 2'b00 || bus.fall !== 2'b00 || bus.period_vld !== 2'b00 || bus.period !== 48'h0) begin
      n_fail++;
      $display("[TB] FAIL midcount_async_clear: got filt=%b rise=%b fall=%b vld=%b period=%h, expected all 0", bus.cadence_filt, bus.rise, bus.fall, bus.period_vld, bus.period);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cadence = 2'b11;
    tick(17);
    n_checks++;
    if (bus.cadence_filt !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL midcount_early: got %b expected 00", bus.cadence_filt);
    end
    tick(1);
    n_checks++;
    if (bus.cadence_filt !== 2'b11 || bus.rise !== 2'b11 || bus.period_vld !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL midcount_unarmed: got filt=%b rise=%b vld=%b, expected 11/11/00", bus.cadence_filt, bus.rise, bus.period_vld);
    end
  endtask

  initial begin
    $display("[TB] starting cadence_filt_mc bench");
    test_reset();
    test_noise();
    test_period();
    test_per_w8();
    test_simultaneous();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cadence_filt_mc.md
Name: cadence_filt_mc

Overview:
Multi-channel successor to the single-channel cadence debounce filter. Each of N raw cadence inputs is synchronised and debounced with a parametrised stability window. Each channel also gives one-cycle rise/fall pulses and measures the clock period between successive filtered rising edges. It sits between the pedal/cadence sensor pins and the cadence/speed computation logic.

Parameters:
N_CH, 2, number of independent cadence channels (>=1)
STABLE_CYC, 50000, consecutive synchronised cycles of a new level required before the filtered output follows (>=2)
PER_W, 24, width of period measurement, saturating

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
cadence  input  N_CH  raw asynchronous cadence inputs, bit i = channel i
cadence_filt  output  N_CH  debounced level per channel
rise  output  N_CH  one-cycle pulse when cadence_filt[i] goes 0->1
fall  output  N_CH  one-cycle pulse when cadence_filt[i] goes 1->0
period  output  N_CH*PER_W  channel i at [i*PER_W +: PER_W]; clocks between the last two filtered rising edges
period_vld  output  N_CH  one-cycle pulse when period slice i is updated

Behaviour:
- Reset state (async, all channels): sync flops=0, stability counter=0, cadence_filt=0, rise=fall=0, period counter=0, period=0, period_vld=0, armed=0.
- Synchroniser: 2-flop per channel (s1<=cadence[i], s2<=s1). No logic is applied to s1.
- Stability counter: width $clog2(STABLE_CYC). On each posedge:
  - If s2==cadence_filt, counter <= 0.
  - Otherwise, if counter==STABLE_CYC-1, cadence_filt toggles and counter <= 0. Else counter increments.
- Latency: cadence_filt changes on the (STABLE_CYC+2)th rising edge, counting the edge that first samples the new raw level as edge 1. This holds only if the raw level is held throughout.
- Any glitch back to the old level before that edge clears the counter, and the window restarts from zero. Noise bursts shorter than STABLE_CYC cycles therefore never change cadence_filt.
- rise/fall are registered and assert on the same edge that cadence_filt changes, for exactly one cycle. rise and fall are never both high for one channel.
- Period counter per channel (PER_W bits):
  - Increments every cycle and saturates at all-ones; it never wraps.
  - On a filtered rising edge, the counter <= 0.
  - If armed, on that same edge period[i] <= sat(counter+1) and period_vld[i] pulses for one cycle. Two rises at edges a and b therefore report b-a.
- First filtered rise after reset: sets armed, loads no period, and gives no period_vld.
- A period of all-ones means overflow (gap >= 2^PER_W - 1 cycles) and is still reported with period_vld.
- period holds its value between updates.
- Channels are fully independent; simultaneous events on several channels are all handled in the same cycle.
- rst_n asserted mid-count: all state returns to its reset value immediately. After release, a channel whose raw input is high needs the full STABLE_CYC+2 edges before cadence_filt rises, and that first rise is not armed.

Decomposition:
- Package cadence_pkg: default STABLE_CYC and PER_W constants, and a function sat_inc(value, width) for saturating increment.
- Sub-module cadence_filt_ch implements one channel: synchroniser, stability counter, edge pulses and period logic. It takes parameters STABLE_CYC and PER_W.
- The top level is a generate loop over N_CH plus packing of the period bus.

Test Plan:
- Reset with cadence=2'b11, release, hold high. Use STABLE_CYC=16. -> cadence_filt=2'b11 on edge 18 after release; rise=2'b11 for one cycle; period_vld stays 0.
- STABLE_CYC=16, ch0 held at the new level for 15 cycles then toggled back, repeated 100 times; ch1 gets random noise bursts of fewer than 16 cycles between 80-cycle stable holds (20 iterations). -> ch0 cadence_filt never changes. ch1 shows exactly 20 transitions, checked by an edge counter against a golden model.
- ch0 clean square wave with filtered rises 200 cycles apart (STABLE_CYC=16). -> first rise gives no period_vld; each later rise gives period_vld[0]=1 for 1 cycle and period slice 0 = 200.
- PER_W=8, filtered rises 300 cycles apart. -> period=8'hFF with period_vld, and no wrap.
- Both channels switched on the same cycle with identical stimulus. -> identical rise/fall/period_vld timing on both, and no cross-channel interaction.
- rst_n pulsed low for 1 cycle while ch0 counter=10 and period counter=150. -> all outputs 0 asynchronously. The next rise is unarmed and produces no period_vld.
